mem_stage_access: RTL and testbench

- MEM-stage data-memory access controller. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs: MemRead, MemWrite, the ALU result used as the address, and the rs2 data used as store data.
- It converts each load or store into a req/ack transaction toward data memory, producing byte enables and aligned write data.
- It stalls the pipeline while the transaction is outstanding.
- It returns aligned, sign/zero-extended load data to the MEM/WB path.

---
 rtl/mem_stage_access_pkg.sv | 37 +++
 rtl/mem_stage_access_load_align.sv | 33 +++
 rtl/mem_stage_access.sv | 144 ++++++++++++++
 tb/tb_mem_stage_access.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_stage_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_ALL = 4'b1111;

    // Unsigned load codes have no store counterpart, so they are illegal for stores.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_access_load_align.sv
// Selects the addressed byte/half of a read word, shifts it to bit 0 and
// sign- or zero-extends it according to funct3.
module mem_stage_access_load_align
    import mem_stage_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_sel = word_i[7:0];
            2'b01:   byte_sel = word_i[15:8];
            2'b10:   byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result_o = {24'h0, byte_sel};
            F3_HU:   result_o = {16'h0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access controller: turns EX/MEM loads/stores into a
// req/ack memory transaction and stalls the pipeline until it completes.
//
// state  | meaning
// S_IDLE | nothing outstanding; a legal access starts, an illegal one faults
// S_WAIT | request held on the memory port until ack or timeout
// S_RESP | load result / timeout reported for one cycle, pipeline released
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        fault_o,
    output logic        timeout_o
);

    // Down-counter holds the remaining WAIT cycles after the current one.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [31:0]      wdata_d, rdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       funct3_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q, timeout_q, rdata_valid_q;
    logic             acc, legal, start, ack_hit, tmo_hit;

    assign acc     = MemRead_i | MemWrite_i;
    assign legal   = access_legal(MemWrite_i, funct3_i, addr_i[1:0]);
    assign start   = ~rst_i & acc & legal & (state_q == S_IDLE);
    assign ack_hit = (state_q == S_WAIT) & mem_ack_i;
    assign tmo_hit = (state_q == S_WAIT) & ~mem_ack_i & (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (ack_hit || tmo_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = (state_q == S_WAIT);
        stall_o   = start | (state_q == S_WAIT);
    end

    always_comb begin
        be_d    = BE_ALL;
        wdata_d = wdata_i;
        if (MemWrite_i) begin
            case (funct3_i)
                F3_B: begin
                    be_d    = BE_B0 << addr_i[1:0];
                    wdata_d = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    be_d    = addr_i[1] ? BE_HI : BE_LO;
                    wdata_d = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    mem_stage_access_load_align u_load_align (
        .word_i    (mem_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .result_o  (rdata_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            funct3_q      <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            timeout_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            fault_q       <= (state_q == S_IDLE) & acc & ~legal;
            timeout_q     <= tmo_hit;
            rdata_valid_q <= ack_hit & ~we_q;
            if (start) begin
                addr_q   <= addr_i;
                wdata_q  <= wdata_d;
                be_q     <= be_d;
                we_q     <= MemWrite_i;
                funct3_q <= funct3_i;
                cnt_q    <= CNT_W'(TIMEOUT - 1);
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (ack_hit && !we_q) begin
                rdata_q <= rdata_d;
            end else if (tmo_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = {addr_q[31:2], 2'b00};
    assign mem_be_o      = be_q;
    assign mem_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign fault_o       = fault_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: expected responses are queued when an access is
// driven and compared when the controller reaches its response cycle.
module tb_mem_stage_access;

    localparam int unsigned TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, fault_o, timeout_o;

    typedef struct {
        logic        is_load;
        logic        tmo;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata;
    int          checks = 0;
    int          errors = 0;

    mem_stage_access #(.TIMEOUT(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .fault_o       (fault_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'hF;
        if (wr && f3 == 3'b000) be = 4'(1 << lo);
        else if (wr && f3 == 3'b001) be = lo[1] ? 4'hC : 4'h3;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        if (f3 == 3'b000) r = {24'h0, wd[7:0]} * 32'h0101_0101;
        else if (f3 == 3'b001) r = {16'h0, wd[15:0]} * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] sh, r;
        sh = word >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h0, sh[7:0]};
            3'b101:  r = {16'h0, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    task automatic drop_inputs;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        funct3_i   = 3'b000;
        addr_i     = 32'h0;
        wdata_i    = 32'h0;
    endtask

    // ack_at = WAIT cycle in which ack is given; 0 = never (timeout)
    task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                             input logic [31:0] word);
        exp_t        e, got;
        int          nwait, stall_cnt, want_wait;
        bit          done;
        logic [31:0] want_addr;
        e.is_load = rd & ~wr;
        e.tmo     = (ack_at == 0);
        if (e.tmo) e.rdata = 32'h0;
        else if (e.is_load) e.rdata = exp_load(word, addr[1:0], f3);
        else e.rdata = model_rdata;
        sb.push_back(e);
        want_wait = (ack_at == 0) ? int'(TMO) : ack_at;
        want_addr = {addr[31:2], 2'b00};

        @(negedge clk_i);
        MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++; $display("FAIL %s idle_req: got %b want 0", name, mem_req_o);
        end
        nwait = 0; done = 0;
        for (int c = 0; c < 3 * int'(TMO) && !done; c++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
            if (mem_req_o) begin
                nwait++;
                if (stall_o) stall_cnt++;
                checks++;
                if (mem_addr_o !== want_addr) begin
                    errors++; $display("FAIL %s addr: got %h want %h", name, mem_addr_o, want_addr);
                end
                checks++;
                if (mem_we_o !== wr || mem_be_o !== exp_be(wr, f3, addr[1:0])) begin
                    errors++; $display("FAIL %s we/be: got %b/%b want %b/%b", name, mem_we_o, mem_be_o,
                                       wr, exp_be(wr, f3, addr[1:0]));
                end
                if (wr) begin
                    checks++;
                    if (mem_wdata_o !== exp_wdata(f3, wd)) begin
                        errors++; $display("FAIL %s wdata: got %h want %h", name, mem_wdata_o, exp_wdata(f3, wd));
                    end
                end
                if (nwait == ack_at) begin
                    mem_ack_i = 1'b1; mem_rdata_i = word;
                end
            end else begin
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s resp_bound: got no response want response within %0d cycles", name, 3 * TMO);
            void'(sb.pop_front());
            drop_inputs();
            return;
        end
        checks++;
        if (nwait != want_wait) begin
            errors++; $display("FAIL %s wait_cycles: got %0d want %0d", name, nwait, want_wait);
        end
        checks++;
        if (stall_cnt != want_wait + 1) begin
            errors++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, want_wait + 1);
        end
        got = sb.pop_front();
        checks++;
        if (stall_o !== 1'b0 || fault_o !== 1'b0) begin
            errors++; $display("FAIL %s resp_stall_fault: got %b%b want 00", name, stall_o, fault_o);
        end
        checks++;
        if (rdata_valid_o !== (got.is_load & ~got.tmo) || timeout_o !== got.tmo) begin
            errors++; $display("FAIL %s resp_flags: got v%b t%b want v%b t%b", name, rdata_valid_o, timeout_o,
                               got.is_load & ~got.tmo, got.tmo);
        end
        checks++;
        if (rdata_o !== got.rdata) begin
            errors++; $display("FAIL %s rdata: got %h want %h", name, rdata_o, got.rdata);
        end
        model_rdata = got.rdata;
        // inputs still present through the response cycle; must not retrigger
        @(posedge clk_i);
        #1 drop_inputs();
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL %s after_resp: got req%b st%b v%b t%b want all 0", name, mem_req_o,
                               stall_o, rdata_valid_o, timeout_o);
        end
        checks++;
        if (rdata_o !== model_rdata) begin
            errors++; $display("FAIL %s rdata_hold: got %h want %h", name, rdata_o, model_rdata);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        drop_inputs();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, stall_o, rdata_valid_o, fault_o, timeout_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                               {mem_req_o, mem_we_o, stall_o, rdata_valid_o, fault_o, timeout_o});
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h want zeros", mem_addr_o, mem_be_o,
                               mem_wdata_o, rdata_o);
        end
        rst_i = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic test_load;
        do_access("lw_100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        do_access("lb_103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234);
        do_access("lbu_103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80FF_1234);
        do_access("lh_102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF_1234);
        do_access("lhu_102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF_1234);
        do_access("lb_101", 1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80FF_1234);
    endtask

    task automatic test_store;
        do_access("sh_102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 2, 32'h5555_5555);
        do_access("sb_101", 1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00EF, 1, 32'h0);
        do_access("sh_200", 1'b0, 1'b1, 3'b001, 32'h200, 32'h1234_5678, 1, 32'h0);
        do_access("rw_sw_104", 1'b1, 1'b1, 3'b010, 32'h104, 32'h1234_5678, 1, 32'hFFFF_FFFF);
    endtask

    task automatic test_fault;
        logic        rd_t [6];
        logic        wr_t [6];
        logic [2:0]  f3_t [6];
        logic [31:0] ad_t [6];
        rd_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wr_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        f3_t = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110};
        ad_t = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            MemRead_i = rd_t[i]; MemWrite_i = wr_t[i]; funct3_i = f3_t[i]; addr_i = ad_t[i];
            wdata_i = 32'hCAFE_F00D;
            #1;
            checks++;
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++; $display("FAIL fault%0d no_stall: got st%b req%b want 00", i, stall_o, mem_req_o);
            end
            @(posedge clk_i);
            #1 drop_inputs();
            @(negedge clk_i);
            checks++;
            if (fault_o !== 1'b1 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
                errors++; $display("FAIL fault%0d pulse: got f%b req%b st%b want 1 0 0", i, fault_o, mem_req_o, stall_o);
            end
            @(negedge clk_i);
            checks++;
            if (fault_o !== 1'b0) begin
                errors++; $display("FAIL fault%0d clear: got %b want 0", i, fault_o);
            end
        end
    endtask

    task automatic test_timeout;
        do_access("sw_timeout", 1'b0, 1'b1, 3'b010, 32'h300, 32'h0BAD_BEEF, 0, 32'h0);
        do_access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 0, 32'h0);
        do_access("lw_after_tmo", 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, int'(TMO), 32'h1357_9BDF);
    endtask

    task automatic test_ack_idle;
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || rdata_valid_o !== 1'b0 || rdata_o !== model_rdata) begin
            errors++; $display("FAIL ack_idle: got req%b v%b rdata %h want 0 0 %h", mem_req_o, rdata_valid_o,
                               rdata_o, model_rdata);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        MemRead_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h200;
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid wait1_req: got %b want 1", mem_req_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        drop_inputs();
        @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid dropped: got req%b st%b v%b want 000", mem_req_o, stall_o, rdata_valid_o);
        end
        rst_i = 1'b0;
        model_rdata = 32'h0;
        do_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1, 32'h2468_ACE0);
    endtask

    task automatic test_back_to_back;
        do_access("b2b_lhu", 1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 1, 32'hFEDC_BA98);
        do_access("b2b_sb", 1'b0, 1'b1, 3'b000, 32'h43, 32'h0000_0077, 1, 32'h0);
        do_access("b2b_lb", 1'b1, 1'b0, 3'b000, 32'h42, 32'h0, 1, 32'hFEDC_BA98);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_fault();
        test_timeout();
        test_ack_idle();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
